// File: rtl/urv_dpram_banked_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : urv_dpram_banked_pkg
//  Description : Shared types and helpers for the banked uRV dual-port RAM:
//                clear-sequencer state encoding and a ceil(log2) helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package urv_dpram_banked_pkg;

  // Clear sequencer: sweep-fill after reset, then serve requests forever.
  typedef enum logic [0:0] {
    URV_MEM_CLEAR = 1'b0,
    URV_MEM_READY = 1'b1
  } urv_mem_state_e;

  // ceil(log2(value)); returns 0 for value <= 1 so single-bank builds work.
  function automatic int urv_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/urv_dpram_bank.sv
`default_nettype none
// ============================================================================
//  Module      : urv_dpram_bank
//  Description : One true-dual-port, byte-enabled, read-first RAM bank.
//                Writes are driven purely by the byte enables; en_*_i only
//                captures read data so writes can happen without a strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module urv_dpram_bank #(
  parameter int DEPTH      = 8192,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_a_i,
  input  logic [DATA_WIDTH/8-1:0] bwe_a_i,
  input  logic [ADDR_WIDTH-1:0]   addr_a_i,
  input  logic [DATA_WIDTH-1:0]   d_a_i,
  output logic [DATA_WIDTH-1:0]   q_a_o,
  input  logic                    en_b_i,
  input  logic [DATA_WIDTH/8-1:0] bwe_b_i,
  input  logic [ADDR_WIDTH-1:0]   addr_b_i,
  input  logic [DATA_WIDTH-1:0]   d_b_i,
  output logic [DATA_WIDTH-1:0]   q_b_o
);

  localparam int NB = DATA_WIDTH / 8;

  logic [NB-1:0][7:0] mem_q [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] q_a_q, q_b_q;

  // Lane writes; port A is applied last so it wins any lane both ports hit.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < NB; l++) begin
      if (bwe_b_i[l]) mem_q[addr_b_i][l] <= d_b_i[8*l +: 8];
      if (bwe_a_i[l]) mem_q[addr_a_i][l] <= d_a_i[8*l +: 8];
    end
  end

  // Read-first capture; the registers hold their value between requests.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_a_q <= '0;
      q_b_q <= '0;
    end else begin
      if (en_a_i) q_a_q <= mem_q[addr_a_i];
      if (en_b_i) q_b_q <= mem_q[addr_b_i];
    end
  end

  assign q_a_o = q_a_q;
  assign q_b_o = q_b_q;

endmodule
`default_nettype wire

// File: rtl/urv_dpram_banked.sv
`default_nettype none
// ============================================================================
//  Module      : urv_dpram_banked
//  Description : Parametrised dual-port, byte-enabled code/data RAM for uRV.
//                Port A = data path, port B = fetch. Banked storage, optional
//                output register, cross-port collision merge, clear sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module urv_dpram_banked
  import urv_dpram_banked_pkg::*;
#(
  parameter int                    g_size         = 65536,
  parameter int                    g_data_width   = 32,
  parameter int                    g_bank_count   = 2,
  parameter int                    g_output_reg   = 0,
  parameter int                    g_clear_on_rst = 1,
  parameter logic [g_data_width-1:0] g_clear_value = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ena_i,
  input  logic                      wea_i,
  input  logic [31:0]               aa_i,
  input  logic [g_data_width/8-1:0] bwea_i,
  input  logic [g_data_width-1:0]   da_i,
  output logic [g_data_width-1:0]   qa_o,
  output logic                      qa_valid_o,
  input  logic                      enb_i,
  input  logic                      web_i,
  input  logic [31:0]               ab_i,
  input  logic [g_data_width/8-1:0] bweb_i,
  input  logic [g_data_width-1:0]   db_i,
  output logic [g_data_width-1:0]   qb_o,
  output logic                      qb_valid_o,
  output logic                      ready_o,
  output logic                      collision_o
);

  localparam int NB  = g_data_width / 8;
  localparam int LB  = urv_clog2(NB);
  localparam int AW  = urv_clog2(g_size);
  localparam int WAW = AW - LB;
  localparam int BB  = urv_clog2(g_bank_count);
  localparam int IAW = WAW - BB;
  localparam int WPB = 2 ** IAW;
  localparam int BSW = (BB > 0) ? BB : 1;

  // Address split: upper byte-address bits fall off, so accesses wrap modulo g_size.
  logic [WAW-1:0] word_a, word_b;
  logic [IAW-1:0] idx_a, idx_b;
  logic [BSW-1:0] bank_a, bank_b;

  assign word_a = WAW'(aa_i >> LB);
  assign word_b = WAW'(ab_i >> LB);
  assign idx_a  = IAW'(word_a);
  assign idx_b  = IAW'(word_b);
  assign bank_a = BSW'(word_a >> IAW);
  assign bank_b = BSW'(word_b >> IAW);

  urv_mem_state_e state_q, state_d;
  logic [IAW-1:0] cnt_q, cnt_d;
  logic           clearing;

  // Clear sequencer state and sweep counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= (g_clear_on_rst != 0) ? URV_MEM_CLEAR : URV_MEM_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep one word per cycle; READY is entered after the last bank word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      URV_MEM_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IAW'(WPB - 1)) state_d = URV_MEM_READY;
      end
      URV_MEM_READY: state_d = URV_MEM_READY;
      default:       state_d = URV_MEM_READY;
    endcase
  end

  assign clearing = (state_q == URV_MEM_CLEAR);
  assign ready_o  = ~clearing;

  // Request qualification and cross-port lane resolution.
  logic          act_a, act_b, wr_a, wr_b, same_word, coll_d;
  logic [NB-1:0] bwe_a_eff, bwe_b_eff;

  assign act_a     = ena_i & ready_o;
  assign act_b     = enb_i & ready_o;
  assign wr_a      = act_a & wea_i;
  assign wr_b      = act_b & web_i;
  assign same_word = (word_a == word_b);
  assign coll_d    = act_a & act_b & same_word & (wr_a | wr_b);
  assign bwe_a_eff = wr_a ? bwea_i : '0;
  // Port B gives up every lane port A also writes in the same word.
  assign bwe_b_eff = wr_b ? (bweb_i & ~((same_word & wr_a) ? bwea_i : '0)) : '0;

  logic [g_data_width-1:0] q_a_bank [g_bank_count];
  logic [g_data_width-1:0] q_b_bank [g_bank_count];

  for (genvar b = 0; b < g_bank_count; b++) begin : g_bank
    logic hit_a, hit_b;
    assign hit_a = (bank_a == BSW'(b));
    assign hit_b = (bank_b == BSW'(b));

    // During the sweep port A of every bank is taken over by the fill write.
    urv_dpram_bank #(
      .DEPTH      (WPB),
      .DATA_WIDTH (g_data_width),
      .ADDR_WIDTH (IAW)
    ) u_bank (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_a_i   (act_a & hit_a),
      .bwe_a_i  (clearing ? {NB{1'b1}} : (hit_a ? bwe_a_eff : '0)),
      .addr_a_i (clearing ? cnt_q : idx_a),
      .d_a_i    (clearing ? g_clear_value : da_i),
      .q_a_o    (q_a_bank[b]),
      .en_b_i   (act_b & hit_b),
      .bwe_b_i  (hit_b ? bwe_b_eff : '0),
      .addr_b_i (idx_b),
      .d_b_i    (db_i),
      .q_b_o    (q_b_bank[b])
    );
  end

  logic           va1_q, vb1_q, coll_q;
  logic [BSW-1:0] bsel_a_q, bsel_b_q;

  // First read stage: strobes, collision pulse, bank select for the output mux.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      va1_q    <= 1'b0;
      vb1_q    <= 1'b0;
      coll_q   <= 1'b0;
      bsel_a_q <= '0;
      bsel_b_q <= '0;
    end else begin
      va1_q  <= act_a;
      vb1_q  <= act_b;
      coll_q <= coll_d;
      if (act_a) bsel_a_q <= bank_a;
      if (act_b) bsel_b_q <= bank_b;
    end
  end

  assign collision_o = coll_q;

  logic [g_data_width-1:0] qa_mux, qb_mux;
  assign qa_mux = q_a_bank[bsel_a_q];
  assign qb_mux = q_b_bank[bsel_b_q];

  if (g_output_reg != 0) begin : g_oreg
    logic [g_data_width-1:0] qa_q, qb_q;
    logic                    va2_q, vb2_q;

    // Second read stage; data only moves on a valid strobe so it holds otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        qa_q  <= '0;
        qb_q  <= '0;
        va2_q <= 1'b0;
        vb2_q <= 1'b0;
      end else begin
        va2_q <= va1_q;
        vb2_q <= vb1_q;
        if (va1_q) qa_q <= qa_mux;
        if (vb1_q) qb_q <= qb_mux;
      end
    end

    assign qa_o       = qa_q;
    assign qb_o       = qb_q;
    assign qa_valid_o = va2_q;
    assign qb_valid_o = vb2_q;
  end else begin : g_no_oreg
    assign qa_o       = qa_mux;
    assign qb_o       = qb_mux;
    assign qa_valid_o = va1_q;
    assign qb_valid_o = vb1_q;
  end

endmodule
`default_nettype wire
